// File: rtl/clock_divide_select_multi_if.sv
// Bus bundle for the multi-channel clock divider/selector.
// The master side drives the request and divide factors.
// The slave side (the divider itself) returns the clocks and status.
interface clock_divide_select_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4,
  parameter int SEL_W  = 2
);
  logic                    enable;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*DIV_W-1:0] div_factor;
  logic [NUM_CH-1:0]       ch_clk;
  logic                    clk_out;
  logic [SEL_W-1:0]        active_ch;
  logic                    busy;

  modport master (
    output enable, sel, div_factor,
    input  ch_clk, clk_out, active_ch, busy
  );

  modport slave (
    input  enable, sel, div_factor,
    output ch_clk, clk_out, active_ch, busy
  );
endinterface

// File: rtl/clock_divide_select_multi.sv
// N-channel 50%-duty clock divider with glitch-free output selection.
// Each channel toggles every D+1 cycles. A new D is picked up only when the
// channel toggles. The select FSM connects clk_out to a channel only while
// that channel is low, and lets a running high pulse finish before it
// disconnects, so clk_out never carries a runt pulse.
module clock_divide_select_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4,
  parameter int SEL_W  = 2
) (
  input logic                       clk,
  input logic                       rst,
  clock_divide_select_multi_if.slave bus
);

  typedef enum logic [1:0] {
    S_OFF,
    S_ARM,
    S_RUN,
    S_PARK
  } state_t;

  // One extra bit so that NUM_CH == 2**SEL_W can be represented.
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] ch_clk_q;
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  active_q, active_d;
  logic [SEL_W-1:0]  sel_eff;
  logic              clk_out_q, clk_out_d;
  logic              cur_lvl;

  // Out-of-range selects fall back to channel 0.
  assign sel_eff = ({1'b0, bus.sel} < NUM_CH_W) ? bus.sel : '0;
  assign cur_lvl = ch_clk_q[active_q];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] shadow_q;
    logic             lvl_q;

    // Count out one half-period; toggle and reload the factor at the wrap.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (rst) begin
        cnt_q    <= '0;
        shadow_q <= bus.div_factor[i*DIV_W +: DIV_W];
        lvl_q    <= 1'b0;
      end else if (cnt_q == shadow_q) begin
        // Reloading only here means a smaller factor can never leave the
        // counter above its limit, so no wrap-around through 2**DIV_W.
        cnt_q    <= '0;
        shadow_q <= bus.div_factor[i*DIV_W +: DIV_W];
        lvl_q    <= ~lvl_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign ch_clk_q[i] = lvl_q;
  end

  // Select FSM registers: state, connected channel and the gated output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OFF;
      active_q  <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      clk_out_q <= clk_out_d;
    end
  end

  // Next-state, next channel and next output level of the select FSM.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    active_d  = active_q;
    clk_out_d = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (bus.enable) begin
          active_d = sel_eff;
          state_d  = S_ARM;
        end
      end

      S_ARM: begin
        if (!bus.enable) begin
          state_d = S_OFF;
        end else if (sel_eff != active_q) begin
          active_d = sel_eff;
        end else if (!cur_lvl) begin
          // Connect only while the channel is low so the first pulse is whole.
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        clk_out_d = cur_lvl;
        if (!bus.enable || (sel_eff != active_q)) begin
          state_d = S_PARK;
        end
      end

      S_PARK: begin
        // Keep following the channel until its high pulse has finished.
        clk_out_d = cur_lvl;
        if (!cur_lvl) begin
          if (bus.enable) begin
            active_d = sel_eff;
            state_d  = S_ARM;
          end else begin
            state_d = S_OFF;
          end
        end
      end

      default: state_d = S_OFF;
    endcase
  end

  assign bus.ch_clk    = ch_clk_q;
  assign bus.clk_out   = clk_out_q;
  assign bus.active_ch = active_q;
  assign bus.busy      = (state_q == S_ARM) || (state_q == S_PARK);

endmodule

// File: tb/tb_clock_divide_select_multi.sv
// Self-checking bench for clock_divide_select_multi.
// Two instances share clk/rst/enable/sel: a 4-channel one and a 3-channel one
// (the latter exercises out-of-range selects). Both are compared every cycle
// against a behavioural model: each channel is a countdown to its next toggle,
// and the output is a gate that follows the chosen channel one cycle late.
module tb_clock_divide_select_multi;

  localparam int DIV_W = 4;
  localparam int SEL_W = 2;

  localparam int M_OFF  = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_PARK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic [1:0]  sel;
  logic [15:0] df;

  int checks = 0;
  int errors = 0;

  // Model state, index [instance][channel]; instance 0 = 4 ch, 1 = 3 ch.
  bit m_lvl  [2][4];
  int m_rem  [2][4];
  int m_d    [2][4];
  int m_mode [2];
  int m_act  [2];
  bit m_out  [2];

  always #5 clk = ~clk;

  clock_divide_select_multi_if #(.NUM_CH(4), .DIV_W(DIV_W), .SEL_W(SEL_W)) if4 ();
  clock_divide_select_multi_if #(.NUM_CH(3), .DIV_W(DIV_W), .SEL_W(SEL_W)) if3 ();

  assign if4.enable     = en;
  assign if4.sel        = sel;
  assign if4.div_factor = df;
  assign if3.enable     = en;
  assign if3.sel        = sel;
  assign if3.div_factor = df[11:0];

  clock_divide_select_multi #(.NUM_CH(4), .DIV_W(DIV_W), .SEL_W(SEL_W)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  clock_divide_select_multi #(.NUM_CH(3), .DIV_W(DIV_W), .SEL_W(SEL_W)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int k);
    for (int i = 0; i < nch(k); i++) begin
      m_lvl[k][i] = 1'b0;
      m_d[k][i]   = int'(df[i*4 +: 4]);
      m_rem[k][i] = m_d[k][i] + 1;
    end
    m_mode[k] = M_OFF;
    m_act[k]  = 0;
    m_out[k]  = 1'b0;
  endtask

  // Advance one clock edge using the inputs present before that edge.
  task automatic model_tick(int k);
    int s;
    bit cur;
    s   = (int'(sel) < nch(k)) ? int'(sel) : 0;
    cur = m_lvl[k][m_act[k]];
    for (int i = 0; i < nch(k); i++) begin
      if (m_rem[k][i] == 1) begin
        m_lvl[k][i] = !m_lvl[k][i];
        m_d[k][i]   = int'(df[i*4 +: 4]);
        m_rem[k][i] = m_d[k][i] + 1;
      end else begin
        m_rem[k][i] = m_rem[k][i] - 1;
      end
    end
    case (m_mode[k])
      M_OFF: begin
        m_out[k] = 1'b0;
        if (en) begin
          m_act[k]  = s;
          m_mode[k] = M_ARM;
        end
      end
      M_ARM: begin
        m_out[k] = 1'b0;
        if (!en) m_mode[k] = M_OFF;
        else if (s != m_act[k]) m_act[k] = s;
        else if (!cur) m_mode[k] = M_RUN;
      end
      M_RUN: begin
        m_out[k] = cur;
        if (!en || (s != m_act[k])) m_mode[k] = M_PARK;
      end
      default: begin
        m_out[k] = cur;
        if (!cur) begin
          if (en) begin
            m_act[k]  = s;
            m_mode[k] = M_ARM;
          end else begin
            m_mode[k] = M_OFF;
          end
        end
      end
    endcase
  endtask

  task automatic compare(int k);
    logic [3:0] exp_ch;
    logic [3:0] obs_ch;
    exp_ch = '0;
    for (int i = 0; i < nch(k); i++) exp_ch[i] = m_lvl[k][i];
    obs_ch = (k == 0) ? if4.ch_clk : {1'b0, if3.ch_clk};
    check($sformatf("ch_clk_%0d", k), 32'(obs_ch), 32'(exp_ch));
    check($sformatf("clk_out_%0d", k),
          32'((k == 0) ? if4.clk_out : if3.clk_out), 32'(m_out[k]));
    check($sformatf("active_ch_%0d", k),
          32'((k == 0) ? if4.active_ch : if3.active_ch), 32'(m_act[k]));
    check($sformatf("busy_%0d", k),
          32'((k == 0) ? if4.busy : if3.busy),
          32'((m_mode[k] == M_ARM) || (m_mode[k] == M_PARK)));
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else     model_tick(k);
    end
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  initial begin
    en  = 1'b0;
    sel = 2'd0;
    df  = {4'd5, 4'd1, 4'd2, 4'd0};
    rst = 1'b1;
    step();
    step();
    check("reset_clk_out", 32'(if4.clk_out), 32'd0);
    check("reset_ch_clk", 32'(if4.ch_clk), 32'd0);
    check("reset_busy", 32'(if4.busy), 32'd0);
    rst = 1'b0;

    // Divide check: ch0 toggles every cycle, ch1 rises on the 3rd edge.
    step();
    check("ch0_first_toggle", 32'(if4.ch_clk[0]), 32'd1);
    step();
    step();
    check("ch1_rise_3rd_edge", 32'(if4.ch_clk[1]), 32'd1);
    repeat (10) step();

    // Enable from OFF while ch1 is high: must hold in ARM first.
    for (int i = 0; i < 20 && if4.ch_clk[1] !== 1'b1; i++) step();
    check("wait_ch1_high", 32'(if4.ch_clk[1]), 32'd1);
    sel = 2'd1;
    en  = 1'b1;
    step();
    check("arm_busy", 32'(if4.busy), 32'd1);
    repeat (20) step();

    // Switch from ch1 to ch3 in the middle of a high pulse.
    for (int i = 0; i < 20 && if4.clk_out !== 1'b1; i++) step();
    check("wait_run_high", 32'(if4.clk_out), 32'd1);
    sel = 2'd3;
    repeat (40) step();

    // Factor change on ch0: 7 -> 1 while the counter sits at 5.
    df[3:0] = 4'd7;
    sel     = 2'd0;
    for (int i = 0; i < 60 && !(m_d[0][0] == 7 && m_rem[0][0] == 3); i++) step();
    check("wait_cnt0_at_5", 32'(m_rem[0][0]), 32'd3);
    df[3:0] = 4'd1;
    repeat (30) step();

    // Out-of-range select on the 3-channel instance.
    sel = 2'd3;
    repeat (20) step();
    check("oor_active_ch", 32'(if3.active_ch), 32'd0);

    // Disable while running: park, then off.
    for (int i = 0; i < 40 && if4.clk_out !== 1'b1; i++) step();
    check("wait_run_before_off", 32'(if4.clk_out), 32'd1);
    en = 1'b0;
    step();
    check("park_busy", 32'(if4.busy), 32'd1);
    repeat (20) step();
    check("off_clk_out", 32'(if4.clk_out), 32'd0);
    check("off_busy", 32'(if4.busy), 32'd0);

    // Randomized traffic against the model.
    en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 11) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 3));
        df[ch*4 +: 4] = 4'($urandom_range(0, 15));
      end
      step();
    end

    // Reset in the middle of a running high pulse.
    en  = 1'b1;
    sel = 2'd2;
    for (int i = 0; i < 200 && if4.clk_out !== 1'b1; i++) step();
    check("wait_run_before_rst", 32'(if4.clk_out), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_clk_out", 32'(if4.clk_out), 32'd0);
    check("rst_mid_ch_clk", 32'(if4.ch_clk), 32'd0);
    check("rst_mid_active", 32'(if4.active_ch), 32'd0);
    check("rst_mid_busy", 32'(if4.busy), 32'd0);
    rst = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divide_select_multi.md
Name: clock_divide_select_multi

Overview:
- Parametrised N-channel clock divider with glitch-free output selection; successor to the single-pair divider/selector in the tiny-user design.
- Each channel produces a 50%-duty divided clock of clk. Divide factors are programmable, and changes are applied only at toggle boundaries.
- A handshaked select FSM switches the output between channels only during low phases, so clk_out never emits runt pulses.
- Feeds the user-design clock output pin and the debug taps.

Parameters:
- NUM_CH, 4, number of divider channels (2..2**SEL_W).
- DIV_W, 4, width of each channel's divide-factor field.
- SEL_W, 2, width of the channel-select input.

Ports:
- clk  input  1  design clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  request the output clock on; 0 parks clk_out low.
- sel  input  SEL_W  requested channel; values >= NUM_CH are treated as 0.
- div_factor  input  NUM_CH*DIV_W  per-channel factor D; channel i uses bits [i*DIV_W +: DIV_W].
- ch_clk  output  NUM_CH  raw divided clocks, registered.
- clk_out  output  1  selected, gated clock, registered.
- active_ch  output  SEL_W  channel currently connected or being armed.
- busy  output  1  high while a switch or park is in progress.

Behaviour:
- Reset (rst=1 at posedge):
  - all channel counters = 0, ch_clk = 0;
  - shadow factors loaded from div_factor;
  - FSM = OFF; clk_out = 0, active_ch = 0, busy = 0.
- Channel i, each posedge:
  - if cnt_i == shadow_i: cnt_i <= 0, ch_clk[i] <= ~ch_clk[i], shadow_i <= div_factor[i];
  - else cnt_i <= cnt_i + 1.
  - Half period = D+1 cycles; full period = 2*(D+1). D=0 gives clk/2; D=2**DIV_W-1 is the maximum and needs no extra bit.
  - A new factor takes effect only at a wrap, so a reduced D never causes a counter overrun or wrap-around. A factor change mid-half-period completes the current half-period with the old D.
- Select FSM (state registered; clk_out registered from the current state):
  - OFF: clk_out <= 0.
    - If enable: active_ch <= sel, go to ARM.
  - ARM: clk_out <= 0; busy = 1.
    - If !enable: go to OFF.
    - Else if sel != active_ch: active_ch <= sel, stay in ARM.
    - Else if ch_clk[active_ch] == 0: go to RUN.
  - RUN: clk_out <= ch_clk[active_ch], i.e. one cycle of latency behind the channel.
    - If !enable or sel != active_ch: go to PARK.
  - PARK: busy = 1; clk_out <= ch_clk[active_ch], so the current high pulse completes.
    - When ch_clk[active_ch] == 0: clk_out <= 0, then go to ARM if enable (active_ch <= sel), else OFF.
- Guarantees:
  - clk_out high pulses are always exactly D+1 cycles of the then-active channel.
  - Low gaps during a switch are >= 1 cycle.
- busy = (state == ARM) || (state == PARK), combinational from the state register.
- Simultaneous events:
  - rst has priority over everything.
  - Deasserting enable in ARM wins over a sel change.
  - sel returning to active_ch while in PARK still completes the park/arm sequence.
- Reset mid-operation: clk_out drops to 0 at the reset edge; this is accepted as the only non-glitch-free event.

Test Plan:
- Divide check:
  - D0=0, D1=2, rst then release -> ch_clk[0] toggles every cycle.
  - ch_clk[1] first rises at the 3rd posedge after reset, falls at the 6th, period 6.
- Enable from OFF:
  - sel=1, D1=2, enable=1 while ch_clk[1]=1 -> FSM holds ARM until ch_clk[1]=0, then RUN.
  - First clk_out rise lags the ch_clk[1] rise by 1 cycle and is high for exactly 3 cycles.
- Switch:
  - In RUN on ch 1 (D=2), set sel=3 (D3=5) mid-high-pulse -> current 3-cycle pulse completes, busy=1, clk_out stays low until ch_clk[3] low.
  - Then 6-cycle high pulses follow; no high pulse shorter than 3 cycles at any time.
- Factor change:
  - D0 from 7 to 1 when cnt_0=5 -> current half-period ends at cnt_0=7 (8 cycles), subsequent half-periods are 2 cycles.
  - No 16-cycle overrun.
- Out-of-range select and disable:
  - NUM_CH=3, sel=3 -> active_ch=0.
  - enable=0 in RUN -> PARK, then OFF with clk_out=0, busy=0.
- Reset mid-RUN:
  - rst pulse while clk_out=1 -> next cycle clk_out=0, ch_clk=0, state OFF, active_ch=0.
